// File: rtl/breath_pkg.sv
`default_nettype none
// ============================================================================
// breath_pkg : shared types and helpers for the breathing-ramp level source
// Revision   : 1.0
// ============================================================================
package breath_pkg;

  localparam int COLOR_W = 2;

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } breath_state_e;

  // Advance a colour index, wrapping at modulus n.
  function automatic logic [COLOR_W-1:0] next_color(input logic [COLOR_W-1:0] idx,
                                                     input int n);
    if (int'(idx) + 1 >= n) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_prescaler.sv
`default_nettype none
// ============================================================================
// ramp_prescaler : enable-gated divide-by-DIV tick generator with sync clear
// Revision       : 1.0
// ============================================================================
module ramp_prescaler #(
  parameter int DIV = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = enable_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/breath_ramp_gen.sv
`default_nettype none
// ============================================================================
// breath_ramp_gen : prescaled triangle ramp with holds, colour index and strobe
// Optional macro  : BREATH_GAMMA_EN (square-law level, +1 clock latency)
// Revision        : 1.0
// ============================================================================
module breath_ramp_gen
  import breath_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIV        = 1024,
  parameter int HOLD_TOP   = 0,
  parameter int HOLD_BOT   = 0,
  parameter int NUM_COLORS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic               restart_i,
  output logic [WIDTH-1:0]   level_o,
  output logic               direction_o,
  output logic [COLOR_W-1:0] color_sel_o,
  output logic               cycle_done_o
);

  localparam logic [WIDTH-1:0] PEAK_M1 = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam int MAXH = (HOLD_TOP > HOLD_BOT) ? HOLD_TOP : HOLD_BOT;
  localparam int HW   = (MAXH < 1) ? 1 : $clog2(MAXH + 1);

  breath_state_e      state_q;
  logic [WIDTH-1:0]   lin_q;
  logic               dir_q;
  logic [COLOR_W-1:0] color_q;
  logic               done_q;
  logic [HW-1:0]      hold_q;
  logic [HW-1:0]      hold_inc;
  logic               tick;

  assign hold_inc = hold_q + 1'b1;

  ramp_prescaler #(.DIV(DIV)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable_i),
    .clear_i  (restart_i),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RISE;
      lin_q   <= '0;
      dir_q   <= 1'b1;
      color_q <= '0;
      done_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (restart_i) begin
        state_q <= RISE;
        lin_q   <= '0;
        dir_q   <= 1'b1;
        color_q <= '0;
        hold_q  <= '0;
      end else if (tick) begin
        unique case (state_q)
          RISE: begin
            lin_q <= lin_q + 1'b1;
            if (lin_q == PEAK_M1) begin
              state_q <= (HOLD_TOP == 0) ? FALL : HOLD_HI;
            end
          end
          HOLD_HI: begin
            if (hold_inc == HW'(HOLD_TOP)) begin
              hold_q  <= '0;
              state_q <= FALL;
            end else begin
              hold_q <= hold_inc;
            end
          end
          FALL: begin
            lin_q <= lin_q - 1'b1;
            dir_q <= 1'b0;
            if (lin_q == ONE) begin
              if (HOLD_BOT == 0) begin
                state_q <= RISE;
                dir_q   <= 1'b1;
                done_q  <= 1'b1;
                color_q <= next_color(color_q, NUM_COLORS);
              end else begin
                state_q <= HOLD_LO;
              end
            end
          end
          HOLD_LO: begin
            if (hold_inc == HW'(HOLD_BOT)) begin
              hold_q  <= '0;
              state_q <= RISE;
              dir_q   <= 1'b1;
              done_q  <= 1'b1;
              color_q <= next_color(color_q, NUM_COLORS);
            end else begin
              hold_q <= hold_inc;
            end
          end
          default: state_q <= RISE;
        endcase
      end
    end
  end

  assign color_sel_o = color_q;

`ifdef BREATH_GAMMA_EN
  // Square-law stage; direction and strobe ride along so all three stay aligned.
  logic [2*WIDTH-1:0] sq;
  logic [WIDTH-1:0]   gam_q;
  logic               gdir_q;
  logic               gdone_q;

  assign sq = {{WIDTH{1'b0}}, lin_q} * {{WIDTH{1'b0}}, lin_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gam_q   <= '0;
      gdir_q  <= 1'b1;
      gdone_q <= 1'b0;
    end else if (restart_i) begin
      gam_q   <= '0;
      gdir_q  <= 1'b1;
      gdone_q <= 1'b0;
    end else begin
      gam_q   <= WIDTH'(sq >> WIDTH);
      gdir_q  <= dir_q;
      gdone_q <= done_q;
    end
  end

  assign level_o      = gam_q;
  assign direction_o  = gdir_q;
  assign cycle_done_o = gdone_q;
`else
  assign level_o      = lin_q;
  assign direction_o  = dir_q;
  assign cycle_done_o = done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_breath_ramp_gen.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for breath_ramp_gen: two configurations driven in lockstep against a
// tick-count reference model (position within breath -> level/direction/colour).
module tb_breath_ramp_gen;

  localparam int W  = 4;
  localparam int M  = 15;
  localparam int NC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic rs = 1'b0;

  logic [W-1:0] lvl_a, lvl_b;
  logic         dir_a, dir_b, done_a, done_b;
  logic [1:0]   col_a, col_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  breath_ramp_gen #(.WIDTH(4), .DIV(1), .HOLD_TOP(0), .HOLD_BOT(0), .NUM_COLORS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .restart_i(rs),
    .level_o(lvl_a), .direction_o(dir_a), .color_sel_o(col_a), .cycle_done_o(done_a)
  );

  breath_ramp_gen #(.WIDTH(4), .DIV(3), .HOLD_TOP(2), .HOLD_BOT(1), .NUM_COLORS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .restart_i(rs),
    .level_o(lvl_b), .direction_o(dir_b), .color_sel_o(col_b), .cycle_done_o(done_b)
  );

  int dv[2] = '{1, 3};
  int ht[2] = '{0, 2};
  int hb[2] = '{0, 1};
  int t[2];
  int pc[2];
  bit dn[2];

  function automatic int period(input int i);
    return 2 * M + ht[i] + hb[i];
  endfunction

  function automatic int exp_level(input int i);
    int p;
    p = t[i] % period(i);
    if (p <= M) return p;
    if (p <= M + ht[i]) return M;
    if (p <= 2 * M + ht[i]) return 2 * M + ht[i] - p;
    return 0;
  endfunction

  function automatic int exp_dir(input int i);
    return ((t[i] % period(i)) <= M + ht[i]) ? 1 : 0;
  endfunction

  function automatic int exp_col(input int i);
    return (t[i] / period(i)) % NC;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; pc[i] = 0; dn[i] = 1'b0;
    end
  endtask

  task automatic model_clock(input bit e, input bit r);
    for (int i = 0; i < 2; i++) begin
      dn[i] = 1'b0;
      if (r) begin
        t[i] = 0; pc[i] = 0;
      end else if (e) begin
        if (pc[i] == dv[i] - 1) begin
          pc[i] = 0;
          t[i]++;
          dn[i] = (t[i] % period(i) == 0);
        end else begin
          pc[i]++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_lvl_a"},  32'(lvl_a),  32'(exp_level(0)));
    chk({tag, "_dir_a"},  32'(dir_a),  32'(exp_dir(0)));
    chk({tag, "_col_a"},  32'(col_a),  32'(exp_col(0)));
    chk({tag, "_done_a"}, 32'(done_a), 32'(dn[0]));
    chk({tag, "_lvl_b"},  32'(lvl_b),  32'(exp_level(1)));
    chk({tag, "_dir_b"},  32'(dir_b),  32'(exp_dir(1)));
    chk({tag, "_col_b"},  32'(col_b),  32'(exp_col(1)));
    chk({tag, "_done_b"}, 32'(done_b), 32'(dn[1]));
  endtask

  task automatic step(input bit e, input bit r, input string tag);
    en = e;
    rs = r;
    @(posedge clk);
    model_clock(e, r);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int pulses_a;
    int first_done_b;
    int k;
    bit hit;

    // Reset state, asserted asynchronously before any clock edge.
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Three breaths of config A, one of config B.
    pulses_a = 0;
    first_done_b = 0;
    for (int c = 1; c <= 99; c++) begin
      step(1'b1, 1'b0, "run");
      if (done_a) pulses_a++;
      if (done_b && first_done_b == 0) first_done_b = c;
      if (c == 15) chk("peak_a_clk15", 32'(lvl_a), 32'd15);
      if (c == 30) begin chk("done_a_30", 32'(done_a), 32'd1); chk("col_a_30", 32'(col_a), 32'd1); end
      if (c == 60) begin chk("done_a_60", 32'(done_a), 32'd1); chk("col_a_60", 32'(col_a), 32'd2); end
      if (c == 90) begin chk("done_a_90", 32'(done_a), 32'd1); chk("col_a_90", 32'(col_a), 32'd0); end
      if (c == 45) chk("peak_hold_b_clk45", 32'(lvl_b), 32'd15);
    end
    chk("pulses_a_99clk", 32'(pulses_a), 32'd3);
    chk("period_b_clocks", 32'(first_done_b), 32'd99);

    // Freeze config B at level 9 while rising.
    hit = 1'b0;
    for (k = 0; k < 300 && !hit; k++) begin
      step(1'b1, 1'b0, "seek9");
      hit = (t[1] % period(1) == 9);
    end
    chk("seek9_found", 32'(hit), 32'd1);
    for (int c = 0; c < 17; c++) begin
      step(1'b0, 1'b0, "freeze");
      chk("freeze_lvl_b", 32'(lvl_b), 32'd9);
    end
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, "resume");

    // Restart on a tick during FALL at level 5 with colour 2 (config A).
    hit = 1'b0;
    for (k = 0; k < 300 && !hit; k++) begin
      step(1'b1, 1'b0, "seek5");
      hit = (t[0] % 30 == 25) && (exp_col(0) == 2);
    end
    chk("seek5_found", 32'(hit), 32'd1);
    step(1'b1, 1'b1, "restart");
    chk("rst_lvl_a", 32'(lvl_a), 32'd0);
    chk("rst_dir_a", 32'(dir_a), 32'd1);
    chk("rst_col_a", 32'(col_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);

    // Randomised enable / restart traffic.
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 79) == 0), "rand");
    end

    // Asynchronous reset between edges at level 12.
    hit = 1'b0;
    for (k = 0; k < 300 && !hit; k++) begin
      step(1'b1, 1'b0, "seek12");
      hit = (exp_level(0) == 12);
    end
    chk("seek12_found", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    chk("async_lvl_a", 32'(lvl_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) step(1'b1, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
